// File: rtl/cgol_board_memory.sv
// Double-buffered 8x8 CGOL board: the engine reads the current bank and writes the next one,
// SWAP exchanges them, and a separate registered read port feeds the display scanner.
module cgol_board_memory #(
   parameter logic [63:0] INIT_BOARD = 64'h0000_1020_1C00_0000,
   parameter int          GEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       memory_operation,
   input  logic [5:0]       memory_operation_address,
   input  logic             i_wr_data,
   output logic             o_rd_data,
   input  logic [5:0]       i_disp_addr,
   output logic             o_disp_data,
   output logic             o_read_bank,
   output logic             o_swap_done,
   output logic [6:0]       o_write_count,
   output logic [GEN_W-1:0] o_gen_count
);

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SWAP  = 2'b10,
      OP_IDLE  = 2'b11
   } mem_op_t;

   logic [1:0][63:0]  r_bank;
   logic              r_rd_sel;
   logic              r_rd_data;
   logic              r_disp_data;
   logic              r_swap_done;
   logic [6:0]        r_write_count;
   logic [GEN_W-1:0]  r_gen_count;

   logic              w_wr_sel;
   mem_op_t           w_op;

   assign w_wr_sel = ~r_rd_sel;
   assign w_op     = mem_op_t'(memory_operation);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank[0]     <= INIT_BOARD;
         r_bank[1]     <= '0;
         r_rd_sel      <= 1'b0;
         r_rd_data     <= 1'b0;
         r_disp_data   <= 1'b0;
         r_swap_done   <= 1'b0;
         r_write_count <= '0;
         r_gen_count   <= '0;
      end else begin
         // Display samples the pre-edge read bank, so a SWAP shows up one cycle later.
         r_disp_data <= r_bank[r_rd_sel][i_disp_addr];
         r_swap_done <= (w_op == OP_SWAP);
         case (w_op)
            OP_READ: r_rd_data <= r_bank[r_rd_sel][memory_operation_address];
            OP_WRITE: begin
               r_bank[w_wr_sel][memory_operation_address] <= i_wr_data;
               if (r_write_count != 7'd64)
                  r_write_count <= r_write_count + 7'd1;
            end
            OP_SWAP: begin
               // The outgoing read bank becomes the next write bank and must start empty.
               r_bank[r_rd_sel] <= '0;
               r_rd_sel         <= w_wr_sel;
               r_write_count    <= '0;
               r_gen_count      <= r_gen_count + {{(GEN_W-1){1'b0}}, 1'b1};
            end
            default: ;
         endcase
      end
   end

   assign o_rd_data     = r_rd_data;
   assign o_disp_data   = r_disp_data;
   assign o_read_bank   = r_rd_sel;
   assign o_swap_done   = r_swap_done;
   assign o_write_count = r_write_count;
   assign o_gen_count   = r_gen_count;

endmodule
